// File: rtl/xsim_ctrl_pkg.sv
// rtl/xsim_ctrl_pkg.sv - shared state/cause encodings for the xsim run controller
// Purpose: state and finish-cause encodings used by xsim_run_ctrl and by the
//          sim top's display logic, plus the reset-hold length helper.
// Ports:   none (package).
package xsim_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } run_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_HOST    = 2'd1,
      CAUSE_TIMEOUT = 2'd2
   } finish_cause_e;

   // A zero-length reset hold still needs one edge of DUT reset.
   function automatic int eff_reset_cycles(input int n);
      return (n < 1) ? 1 : n;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: counts enabled cycles, sticks at all-ones instead of wrapping.
// Ports:   clk    in   clock, posedge
//          clr    in   synchronous clear, wins over inc
//          inc    in   count enable
//          count  out  WIDTH  current count (registered)
//          at_max out  count is all-ones
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             at_max
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && !at_max) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count  = count_q;
   assign at_max = &count_q;

endmodule

// File: rtl/xsim_run_ctrl.sv
// rtl/xsim_run_ctrl.sv - sim run controller: DUT reset hold, cycle count, drained finish
// Purpose: holds DUT reset for RESET_CYCLES after RST, counts cycles, and turns a
//          host finish request into a finish that waits for DRAIN_CYCLES idle cycles.
// Ports:   CLK          in   clock, posedge
//          RST          in   synchronous active-high reset
//          finish_req   in   host end-of-sim request (level)
//          dut_idle     in   DUT has no outstanding work
//          dut_rst_n    out  active-low DUT reset
//          run          out  high in RUN and DRAIN
//          cycle_count  out  CNT_W  cycles since RST release, saturating
//          state        out  2  HOLD/RUN/DRAIN/DONE
//          finish       out  sticky end of simulation
//          finish_cause out  2  0 none, 1 host, 2 timeout
module xsim_run_ctrl
   import xsim_ctrl_pkg::*;
#(
   parameter int RESET_CYCLES   = 20,
   parameter int DRAIN_CYCLES   = 8,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int CNT_W          = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             finish_req,
   input  logic             dut_idle,
   output logic             dut_rst_n,
   output logic             run,
   output logic [CNT_W-1:0] cycle_count,
   output logic [1:0]       state,
   output logic             finish,
   output logic [1:0]       finish_cause
);

   localparam logic [1:0] S_HOLD    = 2'(ST_HOLD);
   localparam logic [1:0] S_RUN     = 2'(ST_RUN);
   localparam logic [1:0] S_DRAIN   = 2'(ST_DRAIN);
   localparam logic [1:0] S_DONE    = 2'(ST_DONE);
   localparam logic [1:0] C_NONE    = 2'(CAUSE_NONE);
   localparam logic [1:0] C_HOST    = 2'(CAUSE_HOST);
   localparam logic [1:0] C_TIMEOUT = 2'(CAUSE_TIMEOUT);

   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(eff_reset_cycles(RESET_CYCLES) - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic             DRAIN_EN     = (DRAIN_CYCLES != 0);
   localparam logic             TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

   logic [1:0]       state_q, state_d;
   logic [1:0]       cause_q, cause_d;
   logic             pending_q, pending_d;
   logic             rst_n_q, rst_n_d;
   logic             run_q, run_d;
   logic             finish_q, finish_d;

   logic [CNT_W-1:0] cycle_cnt, hold_cnt, drain_cnt;
   logic             cycle_max, hold_max, drain_max;
   logic             unused_at_max;
   logic             timeout_hit;

   // Cycle counter stops in DONE so the final value stays visible.
   sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
      .clk    (CLK),
      .clr    (RST),
      .inc    (state_q != S_DONE),
      .count  (cycle_cnt),
      .at_max (cycle_max)
   );

   sat_counter #(.WIDTH(CNT_W)) u_hold_cnt (
      .clk    (CLK),
      .clr    (RST),
      .inc    (state_q == S_HOLD),
      .count  (hold_cnt),
      .at_max (hold_max)
   );

   // Held at zero through RUN so DRAIN always starts from zero; any busy
   // cycle in DRAIN restarts the consecutive-idle count.
   sat_counter #(.WIDTH(CNT_W)) u_drain_cnt (
      .clk    (CLK),
      .clr    (RST || (state_q == S_RUN) || ((state_q == S_DRAIN) && !dut_idle)),
      .inc    ((state_q == S_DRAIN) && dut_idle),
      .count  (drain_cnt),
      .at_max (drain_max)
   );

   assign unused_at_max = ^{cycle_max, hold_max, drain_max};

   assign timeout_hit = TIMEOUT_EN && (cycle_cnt == TIMEOUT_LAST);

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      pending_d = pending_q;
      case (state_q)
         S_HOLD: begin
            if (finish_req) begin
               pending_d = 1'b1;
            end
            if (hold_cnt == HOLD_LAST) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Host request outranks a same-edge timeout.
            if (finish_req || pending_q) begin
               state_d = S_DRAIN;
               cause_d = C_HOST;
            end else if (timeout_hit) begin
               state_d = S_DONE;
               cause_d = C_TIMEOUT;
            end
         end
         S_DRAIN: begin
            // Cause stays HOST even when the watchdog cuts the drain short.
            if (!DRAIN_EN || timeout_hit || (dut_idle && (drain_cnt == DRAIN_LAST))) begin
               state_d = S_DONE;
            end
         end
         default: begin
         end
      endcase
      rst_n_d  = (state_d != S_HOLD);
      run_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
      finish_d = (state_d == S_DONE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_HOLD;
         cause_q   <= C_NONE;
         pending_q <= 1'b0;
         rst_n_q   <= 1'b0;
         run_q     <= 1'b0;
         finish_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         pending_q <= pending_d;
         rst_n_q   <= rst_n_d;
         run_q     <= run_d;
         finish_q  <= finish_d;
      end
   end

   assign dut_rst_n    = rst_n_q;
   assign run          = run_q;
   assign cycle_count  = cycle_cnt;
   assign state        = state_q;
   assign finish       = finish_q;
   assign finish_cause = cause_q;

endmodule

// File: tb/tb_xsim_run_ctrl.sv
// tb/tb_xsim_run_ctrl.sv - directed self-checking bench for xsim_run_ctrl
module tb_xsim_run_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // A: RESET 20, DRAIN 8, no watchdog
   logic        rst_a = 1'b1, req_a = 1'b0, idle_a = 1'b1;
   logic        rstn_a, run_a, fin_a;
   logic [31:0] cc_a;
   logic [1:0]  st_a, cause_a;

   // B: RESET 20, DRAIN 0, watchdog 500
   logic        rst_b = 1'b1, req_b = 1'b0, idle_b = 1'b1;
   logic        rstn_b, run_b, fin_b;
   logic [31:0] cc_b;
   logic [1:0]  st_b, cause_b;

   // C: 4-bit counter to reach saturation quickly
   logic        rst_c = 1'b1, req_c = 1'b0, idle_c = 1'b0;
   logic        rstn_c, run_c, fin_c;
   logic [3:0]  cc_c;
   logic [1:0]  st_c, cause_c;

   xsim_run_ctrl #(.RESET_CYCLES(20), .DRAIN_CYCLES(8), .TIMEOUT_CYCLES(0), .CNT_W(32)) dut_a (
      .CLK(clk), .RST(rst_a), .finish_req(req_a), .dut_idle(idle_a),
      .dut_rst_n(rstn_a), .run(run_a), .cycle_count(cc_a), .state(st_a),
      .finish(fin_a), .finish_cause(cause_a)
   );

   xsim_run_ctrl #(.RESET_CYCLES(20), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(500), .CNT_W(32)) dut_b (
      .CLK(clk), .RST(rst_b), .finish_req(req_b), .dut_idle(idle_b),
      .dut_rst_n(rstn_b), .run(run_b), .cycle_count(cc_b), .state(st_b),
      .finish(fin_b), .finish_cause(cause_b)
   );

   xsim_run_ctrl #(.RESET_CYCLES(3), .DRAIN_CYCLES(8), .TIMEOUT_CYCLES(0), .CNT_W(4)) dut_c (
      .CLK(clk), .RST(rst_c), .finish_req(req_c), .dut_idle(idle_c),
      .dut_rst_n(rstn_c), .run(run_c), .cycle_count(cc_c), .state(st_c),
      .finish(fin_c), .finish_cause(cause_c)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, "_state"}, 32'(st_a), 0);
      check({tag, "_rstn"},  32'(rstn_a), 0);
      check({tag, "_run"},   32'(run_a), 0);
      check({tag, "_cc"},    cc_a, 0);
      check({tag, "_fin"},   32'(fin_a), 0);
      check({tag, "_cause"}, 32'(cause_a), 0);
   endtask

   // Release reset, request at cycle_count 100, drain; abort_at>0 asserts RST
   // after that many drain edges instead of finishing.
   task automatic seq_a(input bit busy, input int abort_at);
      int fe;
      rst_a = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 19) check("a_rstn_hold", 32'(rstn_a), 0);
         if (k == 20) begin
            check("a_rstn_rel", 32'(rstn_a), 1);
            check("a_run_rel",  32'(run_a), 1);
            check("a_cc_rel",   cc_a, 20);
         end
      end
      repeat (80) @(negedge clk);
      check("a_cc_100", cc_a, 100);
      req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
      check("a_state_drain", 32'(st_a), 2);
      check("a_cc_drain",    cc_a, 101);
      fe = busy ? 28 : 8;
      for (int i = 1; i <= fe; i++) begin
         idle_a = (busy && i <= 20 && (i % 5) == 0) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (i == abort_at) begin
            rst_a  = 1'b1;
            idle_a = 1'b1;
            @(negedge clk);
            check_reset_a("a_abort");
            return;
         end
         if (i == fe - 1) check("a_fin_early", 32'(fin_a), 0);
      end
      idle_a = 1'b1;
      check("a_fin",       32'(fin_a), 1);
      check("a_cause",     32'(cause_a), 1);
      check("a_state_done", 32'(st_a), 3);
      check("a_run_done",  32'(run_a), 0);
      check("a_rstn_done", 32'(rstn_a), 1);
      check("a_cc_done",   cc_a, 32'(101 + fe));
      repeat (3) @(negedge clk);
      check("a_cc_frozen", cc_a, 32'(101 + fe));
      check("a_fin_sticky", 32'(fin_a), 1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_reset_a("a_por");

      // idle drain, then reset from DONE
      seq_a(1'b0, 0);
      rst_a = 1'b1;
      @(negedge clk);
      check_reset_a("a_rst_done");

      // busy drain aborted by RST, then the full busy sequence again
      seq_a(1'b1, 12);
      seq_a(1'b1, 0);

      // B: request during HOLD is held until RUN; DRAIN_CYCLES=0
      rst_b = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         req_b = (k == 5);
         @(negedge clk);
         if (k == 19) check("b_pend_hold", 32'(st_b), 0);
         if (k == 20) check("b_pend_run", 32'(st_b), 1);
         if (k == 21) check("b_pend_drain", 32'(st_b), 2);
         if (k == 22) begin
            check("b_pend_fin",   32'(fin_b), 1);
            check("b_pend_cause", 32'(cause_b), 1);
            check("b_pend_cc",    cc_b, 22);
         end
      end
      req_b = 1'b0;
      rst_b = 1'b1;
      @(negedge clk);
      check("b_rst_fin", 32'(fin_b), 0);

      // B: watchdog alone
      rst_b = 1'b0;
      repeat (499) @(negedge clk);
      check("b_to_pre_state", 32'(st_b), 1);
      check("b_to_pre_fin",   32'(fin_b), 0);
      check("b_to_pre_cc",    cc_b, 499);
      @(negedge clk);
      check("b_to_state", 32'(st_b), 3);
      check("b_to_cause", 32'(cause_b), 2);
      check("b_to_fin",   32'(fin_b), 1);
      check("b_to_cc",    cc_b, 500);

      // B: request on the same edge as the watchdog
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      repeat (499) @(negedge clk);
      req_b = 1'b1;
      @(negedge clk);
      req_b = 1'b0;
      check("b_tie_state", 32'(st_b), 2);
      check("b_tie_cause", 32'(cause_b), 1);
      check("b_tie_fin",   32'(fin_b), 0);
      check("b_tie_cc",    cc_b, 500);
      @(negedge clk);
      check("b_tie_done",  32'(st_b), 3);
      check("b_tie_fin2",  32'(fin_b), 1);
      check("b_tie_cause2", 32'(cause_b), 1);
      check("b_tie_cc2",   cc_b, 501);

      // C: counter saturates rather than wrapping
      rst_c = 1'b0;
      repeat (20) @(negedge clk);
      check("c_cc_sat", 32'(cc_c), 15);
      check("c_state",  32'(st_c), 1);
      check("c_rstn",   32'(rstn_c), 1);
      check("c_run",    32'(run_c), 1);
      check("c_fin",    32'(fin_c), 0);
      check("c_cause",  32'(cause_c), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
